instr_fetch: RTL and testbench



---
 rtl/instr_fetch_pkg.sv | 15 +
 rtl/instr_fetch_pc_counter.sv | 36 +++
 rtl/instr_fetch.sv | 91 +++++++++
 tb/tb_instr_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared widths, NOP encoding and fetch state enum
package instr_fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_counter.sv
// rtl/instr_fetch_pc_counter.sv - program counter with load, wrapping increment and hold
module pc_counter
  import instr_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_addr_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Load beats increment; the increment wraps naturally at the register width.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch sequencer: drives the ROM address, fills a one-entry IR
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc_out,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] ir_out,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_addr,
  input  logic               halt_req,
  output logic               halted
);

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] ir_q;
  logic [PC_W-1:0]    ir_pc_q;
  logic               ir_valid_q;
  logic               halted_q;

  logic transfer;
  logic redirect_en;
  logic capture;

  assign transfer    = ir_valid_q & ir_ready;
  assign redirect_en = redirect_valid & (state_q != BOOT);
  // A slot consumed this cycle can be refilled in the same cycle.
  assign capture     = (state_q == RUN) & ~redirect_valid & (~ir_valid_q | transfer);

  pc_counter u_pc_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (redirect_en),
    .load_addr_i (redirect_addr),
    .inc_i       (capture),
    .pc_o        (pc_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      ir_q       <= NOP_INSTR;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            ir_valid_q <= 1'b0;
          end else begin
            if (capture) begin
              ir_q       <= rom_data;
              ir_pc_q    <= pc_out;
              ir_valid_q <= 1'b1;
            end
            if (halt_req) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end
          end
        end
        HALT: begin
          if (redirect_valid) begin
            ir_valid_q <= 1'b0;
            state_q    <= RUN;
            halted_q   <= 1'b0;
          end else if (transfer) begin
            ir_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign ir_out   = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with ROM[i] = 0x0100 + i
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc_out;
  logic [15:0] rom_data;
  logic [15:0] ir_out;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        halt_req;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_out         (pc_out),
    .rom_data       (rom_data),
    .ir_out         (ir_out),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt_req       (halt_req),
    .halted         (halted)
  );

  assign rom_data = 16'h0100 | {8'h00, pc_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ir(input string tag, input logic [7:0] pc, input logic [7:0] next_pc);
    check({tag, ".ir_valid"}, 32'(ir_valid), 32'd1);
    check({tag, ".ir_pc"},    32'(ir_pc),    32'(pc));
    check({tag, ".ir_out"},   32'(ir_out),   32'h0100 + 32'(pc));
    check({tag, ".pc_out"},   32'(pc_out),   32'(next_pc));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".pc_out"},   32'(pc_out),   32'h0);
    check({tag, ".ir_out"},   32'(ir_out),   32'h0);
    check({tag, ".ir_pc"},    32'(ir_pc),    32'h0);
    check({tag, ".ir_valid"}, 32'(ir_valid), 32'h0);
    check({tag, ".halted"},   32'(halted),   32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    ir_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 8'h00;
    halt_req = 1'b0;
    step();
    step();
    check_reset("reset");

    // Release: BOOT edge, then first capture of ROM[0].
    rst_n = 1'b1;
    step();
    check("boot.ir_valid", 32'(ir_valid), 32'd0);
    check("boot.pc_out", 32'(pc_out), 32'd0);
    step();
    check_ir("first", 8'h00, 8'h01);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_ir("stream", 8'(i), 8'(i + 1));
    end

    // Stall with ir_pc=5 held valid.
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ir("stall", 8'h05, 8'h06);
    end
    ir_ready = 1'b1;
    step();
    check_ir("resume", 8'h06, 8'h07);

    for (int i = 7; i <= 17; i++) begin
      step();
    end
    check_ir("pre_redir", 8'h11, 8'h12);

    redirect_valid = 1'b1;
    redirect_addr = 8'h00;
    step();
    check("redir.ir_valid", 32'(ir_valid), 32'd0);
    check("redir.pc_out", 32'(pc_out), 32'h00);
    redirect_valid = 1'b0;
    step();
    check_ir("redir_fill", 8'h00, 8'h01);

    // Wrap 0xFE -> 0xFF -> 0x00.
    redirect_valid = 1'b1;
    redirect_addr = 8'hFE;
    step();
    redirect_valid = 1'b0;
    check("wrap.pc_out", 32'(pc_out), 32'hFE);
    step();
    check_ir("wrap_fe", 8'hFE, 8'hFF);
    step();
    check_ir("wrap_ff", 8'hFF, 8'h00);
    step();
    check_ir("wrap_00", 8'h00, 8'h01);
    step();
    step();
    step();
    check_ir("pre_halt", 8'h03, 8'h04);

    // Halt while stalled at ir_pc=3, then drain.
    halt_req = 1'b1;
    ir_ready = 1'b0;
    step();
    halt_req = 1'b0;
    check("halt.halted", 32'(halted), 32'd1);
    check_ir("halt_hold", 8'h03, 8'h04);
    step();
    check_ir("halt_hold2", 8'h03, 8'h04);
    ir_ready = 1'b1;
    step();
    check("halt_drain.ir_valid", 32'(ir_valid), 32'd0);
    check("halt_drain.pc_out", 32'(pc_out), 32'h04);
    step();
    check("halt_idle.ir_valid", 32'(ir_valid), 32'd0);
    check("halt_idle.pc_out", 32'(pc_out), 32'h04);
    check("halt_idle.halted", 32'(halted), 32'd1);

    redirect_valid = 1'b1;
    redirect_addr = 8'h09;
    step();
    redirect_valid = 1'b0;
    check("unhalt.halted", 32'(halted), 32'd0);
    check("unhalt.pc_out", 32'(pc_out), 32'h09);
    check("unhalt.ir_valid", 32'(ir_valid), 32'd0);
    step();
    check_ir("unhalt_fill", 8'h09, 8'h0A);

    // halt_req together with redirect: redirect wins.
    halt_req = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 8'h20;
    step();
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    check("both.halted", 32'(halted), 32'd0);
    check("both.pc_out", 32'(pc_out), 32'h20);
    step();
    check_ir("both_fill", 8'h20, 8'h21);
    check("both_fill.halted", 32'(halted), 32'd0);

    // Reset in the middle of a stall.
    ir_ready = 1'b0;
    step();
    check_ir("pre_rst_stall", 8'h20, 8'h21);
    rst_n = 1'b0;
    step();
    check_reset("rst_stall");

    // Redirect is ignored in BOOT.
    rst_n = 1'b1;
    ir_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 8'h40;
    step();
    redirect_valid = 1'b0;
    check("boot_redir.pc_out", 32'(pc_out), 32'h00);
    check("boot_redir.ir_valid", 32'(ir_valid), 32'd0);
    step();
    check_ir("boot_redir_fill", 8'h00, 8'h01);

    // Reset on a redirect edge.
    redirect_valid = 1'b1;
    redirect_addr = 8'h30;
    rst_n = 1'b0;
    step();
    redirect_valid = 1'b0;
    check_reset("rst_redir");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
